sram_arbiter: RTL
=================

Name: sram_arbiter

Overview:
Two-port arbiter and sequencer for the external asynchronous 16-bit x 256K SRAM (active-low CS/OE/WE). Two requesters (port A, port B) issue single-word read or write transactions. The block grants the SRAM round-robin, generates the strobe sequences, and returns read data. It replaces direct strobe toggling by test or pattern logic and sits between those clients and the SRAM pins.

Parameters:
READ_WAIT, 1, cycles between asserting OE with a stable address and latching data (1..15)
ADDR_W, 18, SRAM address width
DATA_W, 16, SRAM data width

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous reset, active-high
a_req  in  1  port A request, level; held until a_ack
a_we  in  1  port A: 1 = write, 0 = read
a_addr  in  ADDR_W  port A address
a_wdata  in  DATA_W  port A write data
a_ack  out  1  port A one-cycle completion pulse
a_rdata  out  DATA_W  port A read data, valid from a_ack, held until the next A read completes
b_req, b_we, b_addr, b_wdata, b_ack, b_rdata  same as port A, for port B
sram_addr  out  ADDR_W  SRAM address pins
sram_data  inout  DATA_W  SRAM data pins
sram_cs  out  1  chip select, active-low
sram_oe  out  1  output enable, active-low
sram_we  out  1  write enable, active-low
busy  out  1  high while a transaction is in flight (state != IDLE)
owner_b  out  1  1 = current or last transaction belongs to port B

Behaviour:
- Reset values (asynchronous, also mid-transaction): state=IDLE; sram_cs=1, sram_oe=1, sram_we=1; sram_data=Z; sram_addr=0; a_ack=b_ack=0; a_rdata=b_rdata=0; busy=0; last grant = B, so A wins the first tie.
- All SRAM outputs and acks are registered. sram_data is driven only in W_SETUP, W_PULSE and W_HOLD; it is Z otherwise.
- IDLE: cs=oe=we=1. The arbiter samples requests only here.
  - One request: grant it.
  - Both requests: grant the port not granted last.
  - On grant, register addr, wdata, we and owner. Next state is W_SETUP or R_SETUP.
- Write, 3 cycles after grant:
  - W_SETUP: cs=0, we=1, addr and data driven.
  - W_PULSE: we=0.
  - W_HOLD: we=1, addr and data still driven, ack pulse to owner.
  - Then IDLE.
- Read, 2+READ_WAIT cycles after grant:
  - R_SETUP: cs=0, oe=0, addr driven.
  - R_WAIT: counter counts READ_WAIT cycles.
  - R_LATCH: capture sram_data into the owner's rdata, ack pulse, oe stays 0.
  - Then IDLE.
- Every transaction returns through IDLE, where oe=1 and the bus is Z. This one-cycle turnaround prevents bus contention on read to write.
- Throughput: write 4 clk per word; read 3+READ_WAIT clk per word.
- Handshake: inputs must be stable from req high until ack. If req is still high in the cycle after ack, it is a new transaction. Dropping req before ack is illegal; the in-flight transaction completes regardless.
- Fairness: with both ports continuously requesting, grants alternate strictly A, B, A, B. Neither port waits more than one transaction.
- The non-owner's rdata and ack are never disturbed.

Optional Feature:
SRAM_ARB_PRIO_EN
- Defined: fixed priority; port A always wins a tie in IDLE; port B is served only when a_req=0 in IDLE.
- Undefined: round-robin as above.
- Ports and timing are identical in both builds.

Test Plan:
- Reset mid-write: assert rst during W_PULSE -> immediately sram_we=1, sram_cs=1, sram_data=Z, busy=0; no ack issued.
- Single A write, addr=0x3FFFF, wdata=0xA5A5 -> we low exactly 1 cycle; data and addr stable from W_SETUP through W_HOLD; a_ack on the 3rd cycle after grant; b_ack stays 0.
- A read-back of 0x3FFFF with READ_WAIT=1 -> a_ack 3 cycles after grant, a_rdata=0xA5A5. Repeat with READ_WAIT=3 -> 5 cycles.
- Both ports request writes continuously for 8 transactions -> owner_b sequence 0,1,0,1,0,1,0,1. With SRAM_ARB_PRIO_EN: all A while a_req=1.
- A read immediately followed by B write to the same address -> an IDLE cycle with oe=1 and bus Z between R_LATCH and W_SETUP; no cycle with oe=0 while the bus is driven.
- Random 1000-transaction mix of reads and writes from both ports against an SRAM model -> every read returns the last value written to that address; zero protocol violations.

Source files
------------

// File: rtl/sram_arbiter.sv
// Two-port arbiter and strobe sequencer for an asynchronous 16-bit SRAM (active-low CS/OE/WE).
// Build option SRAM_ARB_PRIO_EN: port A has fixed priority; otherwise round-robin.
module sram_arbiter #(
   parameter int READ_WAIT = 1,
   parameter int ADDR_W    = 18,
   parameter int DATA_W    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              a_req,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              a_ack,
   output logic [DATA_W-1:0] a_rdata,
   input  logic              b_req,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_ack,
   output logic [DATA_W-1:0] b_rdata,
   output logic [ADDR_W-1:0] sram_addr,
   inout  wire  [DATA_W-1:0] sram_data,
   output logic              sram_cs,
   output logic              sram_oe,
   output logic              sram_we,
   output logic              busy,
   output logic              owner_b
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_W_SETUP = 3'd1,
      S_W_PULSE = 3'd2,
      S_W_HOLD  = 3'd3,
      S_R_SETUP = 3'd4,
      S_R_WAIT  = 3'd5,
      S_R_LATCH = 3'd6
   } state_t;

   localparam logic [3:0] CNT_LAST = 4'(READ_WAIT - 1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
   logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              owner_q, owner_d;
   logic              cs_q, cs_d;
   logic              oe_q, oe_d;
   logic              we_q, we_d;
   logic              drive_q, drive_d;
   logic              a_ack_q, a_ack_d;
   logic              b_ack_q, b_ack_d;
   logic              pick_a_s, pick_b_s, we_sel_s;

   // Arbitration, only meaningful while IDLE; owner_q doubles as "last granted port".
   always_comb begin
      pick_a_s = 1'b0;
      pick_b_s = 1'b0;
`ifdef SRAM_ARB_PRIO_EN
      if (a_req) begin
         pick_a_s = 1'b1;
      end else if (b_req) begin
         pick_b_s = 1'b1;
      end else begin
         pick_a_s = 1'b0;
      end
`else
      if (a_req && (!b_req || owner_q)) begin
         pick_a_s = 1'b1;
      end else if (b_req) begin
         pick_b_s = 1'b1;
      end else begin
         pick_a_s = 1'b0;
      end
`endif
      we_sel_s = pick_b_s ? b_we : a_we;
   end

   // Next state; strobe values computed here are those of the state being entered.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      owner_d   = owner_q;
      cnt_d     = cnt_q;
      a_rdata_d = a_rdata_q;
      b_rdata_d = b_rdata_q;
      cs_d      = 1'b1;
      oe_d      = 1'b1;
      we_d      = 1'b1;
      drive_d   = 1'b0;
      a_ack_d   = 1'b0;
      b_ack_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (pick_a_s || pick_b_s) begin
               owner_d = pick_b_s;
               addr_d  = pick_b_s ? b_addr : a_addr;
               wdata_d = pick_b_s ? b_wdata : a_wdata;
               cs_d    = 1'b0;
               if (we_sel_s) begin
                  state_d = S_W_SETUP;
                  drive_d = 1'b1;
               end else begin
                  state_d = S_R_SETUP;
                  oe_d    = 1'b0;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_W_SETUP: begin
            state_d = S_W_PULSE;
            cs_d    = 1'b0;
            we_d    = 1'b0;
            drive_d = 1'b1;
         end
         S_W_PULSE: begin
            state_d = S_W_HOLD;
            cs_d    = 1'b0;
            drive_d = 1'b1;
            a_ack_d = !owner_q;
            b_ack_d = owner_q;
         end
         S_W_HOLD: begin
            state_d = S_IDLE;
         end
         S_R_SETUP: begin
            state_d = S_R_WAIT;
            cs_d    = 1'b0;
            oe_d    = 1'b0;
            cnt_d   = 4'd0;
         end
         S_R_WAIT: begin
            cs_d = 1'b0;
            oe_d = 1'b0;
            if (cnt_q == CNT_LAST) begin
               state_d = S_R_LATCH;
               a_ack_d = !owner_q;
               b_ack_d = owner_q;
               if (owner_q) begin
                  b_rdata_d = sram_data;
               end else begin
                  a_rdata_d = sram_data;
               end
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         S_R_LATCH: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers; reset leaves B as last grant so A wins the first tie.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         addr_q    <= {ADDR_W{1'b0}};
         wdata_q   <= {DATA_W{1'b0}};
         a_rdata_q <= {DATA_W{1'b0}};
         b_rdata_q <= {DATA_W{1'b0}};
         cnt_q     <= 4'd0;
         owner_q   <= 1'b1;
         cs_q      <= 1'b1;
         oe_q      <= 1'b1;
         we_q      <= 1'b1;
         drive_q   <= 1'b0;
         a_ack_q   <= 1'b0;
         b_ack_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         a_rdata_q <= a_rdata_d;
         b_rdata_q <= b_rdata_d;
         cnt_q     <= cnt_d;
         owner_q   <= owner_d;
         cs_q      <= cs_d;
         oe_q      <= oe_d;
         we_q      <= we_d;
         drive_q   <= drive_d;
         a_ack_q   <= a_ack_d;
         b_ack_q   <= b_ack_d;
      end
   end

   assign sram_data = drive_q ? wdata_q : {DATA_W{1'bz}};
   assign sram_addr = addr_q;
   assign sram_cs   = cs_q;
   assign sram_oe   = oe_q;
   assign sram_we   = we_q;
   assign a_ack     = a_ack_q;
   assign b_ack     = b_ack_q;
   assign a_rdata   = a_rdata_q;
   assign b_rdata   = b_rdata_q;
   assign owner_b   = owner_q;
   assign busy      = (state_q != S_IDLE);

endmodule
